ifft64_out_packer: RTL and testbench
====================================

Name: ifft64_out_packer

Overview:
- Collects the streamed IFFT output (two complex 16-bit samples per cycle, 32 cycles per 64-point frame) and repacks each frame into four 512-bit bank words.
- Drives a write-side result bank with a valid/ready handshake and a frame address.
- Sits after ifft64_radix2_top. It is the inverse of the input bank path, which presents 512-bit words by bank_addr.

Parameters:
- SAMPLE_W, 16, width of one real or imaginary sample.
- SAMPLES_PER_WORD, 32, samples per lane per frame; also the cycles per frame.
- ADDR_W, 10, result-bank address width.

Ports:
- CLK  input  1  clock, rising edge.
- RST  input  1  synchronous reset, active-high.
- in_valid  input  1  sample-pair strobe; connects to start_check.
- in0_re  input  SAMPLE_W  lane-0 real sample.
- in0_im  input  SAMPLE_W  lane-0 imaginary sample.
- in1_re  input  SAMPLE_W  lane-1 real sample.
- in1_im  input  SAMPLE_W  lane-1 imaginary sample.
- out_valid  output  1  packed frame available.
- out_ready  input  1  bank accepts the word set this cycle.
- out0_re  output  SAMPLE_W*SAMPLES_PER_WORD  packed lane-0 real word.
- out0_im  output  SAMPLE_W*SAMPLES_PER_WORD  packed lane-0 imaginary word.
- out1_re  output  SAMPLE_W*SAMPLES_PER_WORD  packed lane-1 real word.
- out1_im  output  SAMPLE_W*SAMPLES_PER_WORD  packed lane-1 imaginary word.
- out_addr  output  ADDR_W  bank address of the presented frame.
- overflow  output  1  sticky: a completed frame was dropped.
- busy  output  1  assembly is in progress or a frame is held.

Behaviour:
- Clock and reset: one clock, CLK. Reset RST is synchronous, active-high.
- Reset values: all outputs 0, including out_valid, out_addr, overflow, busy and every out word. Sample counter 0; assembly and holding buffers cleared.
- Packing order: the k-th accepted sample of a frame (k = 0..31) goes to bits [W-1-16k : W-16-16k], where W = 512. Sample 0 therefore occupies bits 511:496 (MSB-first, the order the bank text files use). All four lanes are packed identically and in parallel. No arithmetic is performed; samples are copied bit-exact.
- Sample counter: 5 bits. It advances only on in_valid=1 and holds during gaps; gaps of any length are legal. It wraps 31 -> 0 on the 32nd sample.
- Buffers:
  - Assembly buffer: 4 x 512 bits, written one slot per accepted sample.
  - Holding buffer: 4 x 512 bits, drives the out words.
- State machine:
  - EMPTY: out_valid=0.
  - FULL: out_valid=1; the holding buffer is valid.
- Frame completion (in_valid=1 with counter=31, cycle N):
  - EMPTY: the assembly contents, including the cycle-N sample, transfer to holding. out_valid=1 from cycle N+1. Latency from the last sample to out_valid is 1 cycle.
  - FULL with out_ready=1 in cycle N: the pop and the transfer happen in the same edge, so out_valid stays 1 with the new words.
  - FULL with out_ready=0: the new frame is discarded, holding is unchanged, overflow=1 from N+1 until RST, and out_addr is not advanced.
- Handshake:
  - Transfer occurs when out_valid and out_ready are both 1.
  - out_addr increments by 1 on each transfer, modulo 2^ADDR_W (1023 -> 0).
  - While out_valid=1, the out words and out_addr are stable until transfer.
  - out_ready while EMPTY has no effect.
- Assembly continues during FULL. A new frame may begin the cycle after completion with no bubble; the counter has already wrapped.
- busy = (counter != 0) | out_valid.
- Reset mid-frame: the partial frame is discarded, any held frame is discarded, and out_addr returns to 0. The first sample after reset is sample 0.
- in_valid and RST in the same cycle: reset wins and the sample is ignored.

Test Plan:
- Single frame: after reset, in_valid=1 for 32 cycles with in0_re=k, in0_im=0x100+k, in1_re=0x200+k, in1_im=0x300+k; out_ready=1.
  -> out_valid for exactly one cycle, the cycle after the 32nd sample.
  -> out0_re[511:496]=0x0000, out0_re[15:0]=0x001F, out1_im[15:0]=0x031F.
  -> out_addr=0, then 1 after the transfer.
- Back-to-back: 1000 continuous frames with random data and out_ready=1.
  -> Every frame matches a model with MSB-first packing.
  -> out_addr sequence is 0..999 and overflow stays 0.
- Gapped input: in_valid toggles 1,0,1,0 across 64 cycles.
  -> One frame, with content identical to the ungapped case.
  -> out_valid rises 1 cycle after the 32nd in_valid.
- Backpressure:
  - With out_ready=0, stream two full frames.
    -> The first frame is held.
    -> The second is dropped, overflow=1 and out_addr=0.
  - Raise out_ready.
    -> The first frame is transferred and out_addr=1.
  - Repeat with out_ready=1 in the exact completion cycle of frame 2.
    -> No drop and no overflow.
- Address wrap: ADDR_W=3, 9 frames with ready=1.
  -> out_addr runs 0..7, 0, and is 1 after the 9th transfer.
- Reset mid-frame: RST=1 for one cycle after 17 samples, then 32 new samples.
  -> The packed frame contains only the new samples, out_addr=0, overflow=0, busy=0 during reset.

Source files
------------

// File: rtl/ifft64_out_packer.sv
// Repacks the streamed two-lane complex IFFT output into four MSB-first bank words
// per frame and presents them to the result bank with a valid/ready handshake.
module ifft64_out_packer #(
  parameter int SAMPLE_W         = 16,
  parameter int SAMPLES_PER_WORD = 32,
  parameter int ADDR_W           = 10
) (
  input  logic                                 CLK,
  input  logic                                 RST,
  input  logic                                 in_valid,
  input  logic [SAMPLE_W-1:0]                  in0_re,
  input  logic [SAMPLE_W-1:0]                  in0_im,
  input  logic [SAMPLE_W-1:0]                  in1_re,
  input  logic [SAMPLE_W-1:0]                  in1_im,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic [SAMPLE_W*SAMPLES_PER_WORD-1:0] out0_re,
  output logic [SAMPLE_W*SAMPLES_PER_WORD-1:0] out0_im,
  output logic [SAMPLE_W*SAMPLES_PER_WORD-1:0] out1_re,
  output logic [SAMPLE_W*SAMPLES_PER_WORD-1:0] out1_im,
  output logic [ADDR_W-1:0]                    out_addr,
  output logic                                 overflow,
  output logic                                 busy
);
  localparam int W     = SAMPLE_W * SAMPLES_PER_WORD;
  localparam int CNT_W = $clog2(SAMPLES_PER_WORD);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(SAMPLES_PER_WORD - 1);

  typedef enum logic {EMPTY, FULL} state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                ovf_q, ovf_d;
  logic                load;
  logic [W-1:0]        asm_q  [4];
  logic [W-1:0]        asm_d  [4];
  logic [W-1:0]        hold_q [4];
  logic [W-1:0]        hold_d [4];
  logic [SAMPLE_W-1:0] smp    [4];
  logic                complete;
  logic                pop;

  assign smp[0]   = in0_re;
  assign smp[1]   = in0_im;
  assign smp[2]   = in1_re;
  assign smp[3]   = in1_im;
  assign complete = in_valid && (cnt_q == LAST);
  assign pop      = (state_q == FULL) && out_ready;

  // Shifting in at the LSB leaves the first sample of a frame in the top slot
  // once the whole frame has arrived, giving the MSB-first layout directly.
  always_comb begin
    cnt_d = cnt_q;
    for (int i = 0; i < 4; i++) asm_d[i] = asm_q[i];
    if (in_valid) begin
      cnt_d = complete ? '0 : cnt_q + CNT_W'(1);
      for (int i = 0; i < 4; i++) asm_d[i] = {asm_q[i][W-SAMPLE_W-1:0], smp[i]};
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    ovf_d   = ovf_q;
    load    = 1'b0;
    if (pop) addr_d = addr_q + ADDR_W'(1);
    case (state_q)
      EMPTY: begin
        if (complete) begin
          load    = 1'b1;
          state_d = FULL;
        end
      end
      FULL: begin
        // A frame finishing while the held one is still unaccepted is dropped.
        if (complete && out_ready) load = 1'b1;
        else if (complete)         ovf_d = 1'b1;
        else if (out_ready)        state_d = EMPTY;
      end
      default: state_d = EMPTY;
    endcase
    for (int i = 0; i < 4; i++) hold_d[i] = load ? asm_d[i] : hold_q[i];
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= EMPTY;
      cnt_q   <= '0;
      addr_q  <= '0;
      ovf_q   <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        asm_q[i]  <= '0;
        hold_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      ovf_q   <= ovf_d;
      for (int i = 0; i < 4; i++) begin
        asm_q[i]  <= asm_d[i];
        hold_q[i] <= hold_d[i];
      end
    end
  end

  assign out_valid = (state_q == FULL);
  assign out0_re   = hold_q[0];
  assign out0_im   = hold_q[1];
  assign out1_re   = hold_q[2];
  assign out1_im   = hold_q[3];
  assign out_addr  = addr_q;
  assign overflow  = ovf_q;
  assign busy      = (cnt_q != '0) || out_valid;
endmodule

// File: tb/tb_ifft64_out_packer.sv
// Directed bench for ifft64_out_packer: table of linear-ramp frames plus
// hand-written sequences for streaming, backpressure, address wrap and reset.
module tb_ifft64_out_packer;
  localparam int SW = 16;
  localparam int N  = 32;
  localparam int W  = SW * N;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic          RST, in_valid, out_ready;
  logic [SW-1:0] in0_re, in0_im, in1_re, in1_im;
  logic          out_valid, overflow, busy;
  logic [W-1:0]  out0_re, out0_im, out1_re, out1_im;
  logic [9:0]    out_addr;
  logic          w_valid, w_overflow, w_busy;
  logic [W-1:0]  w0_re, w0_im, w1_re, w1_im;
  logic [2:0]    w_addr;

  ifft64_out_packer dut (
    .CLK(CLK), .RST(RST), .in_valid(in_valid),
    .in0_re(in0_re), .in0_im(in0_im), .in1_re(in1_re), .in1_im(in1_im),
    .out_valid(out_valid), .out_ready(out_ready),
    .out0_re(out0_re), .out0_im(out0_im), .out1_re(out1_re), .out1_im(out1_im),
    .out_addr(out_addr), .overflow(overflow), .busy(busy)
  );

  ifft64_out_packer #(.ADDR_W(3)) dutw (
    .CLK(CLK), .RST(RST), .in_valid(in_valid),
    .in0_re(in0_re), .in0_im(in0_im), .in1_re(in1_re), .in1_im(in1_im),
    .out_valid(w_valid), .out_ready(out_ready),
    .out0_re(w0_re), .out0_im(w0_im), .out1_re(w1_re), .out1_im(w1_im),
    .out_addr(w_addr), .overflow(w_overflow), .busy(w_busy)
  );

  typedef struct {
    string           name;
    bit              gap;
    logic [3:0][15:0] base;
    logic [15:0]     stp;
    logic [15:0]     e_top0re;
    logic [15:0]     e_lo0re;
    logic [15:0]     e_lo1im;
  } vec_t;

  vec_t          vecs [4];
  logic [SW-1:0] smp [4][N];
  logic [W-1:0]  a_w [4];
  int            n_tests = 0;
  int            n_fail  = 0;
  bit            bb_en   = 1'b0;
  int            bb_cnt  = 0;

  always @(negedge CLK) if (bb_en && out_valid) bb_cnt++;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [W-1:0] pack(input int l);
    logic [W-1:0] w;
    w = '0;
    for (int k = 0; k < N; k++) w[W-1-SW*k -: SW] = smp[l][k];
    return w;
  endfunction

  task automatic chk_frame(input string nm);
    chk({nm, "_0re"}, out0_re, pack(0));
    chk({nm, "_0im"}, out0_im, pack(1));
    chk({nm, "_1re"}, out1_re, pack(2));
    chk({nm, "_1im"}, out1_im, pack(3));
  endtask

  task automatic fill_lin(input logic [3:0][15:0] base, input logic [15:0] stp);
    for (int l = 0; l < 4; l++)
      for (int k = 0; k < N; k++) smp[l][k] = 16'(base[l] + stp * 16'(k));
  endtask

  task automatic fill_rand();
    for (int l = 0; l < 4; l++)
      for (int k = 0; k < N; k++) smp[l][k] = 16'($urandom);
  endtask

  task automatic drive(input int lo, input int hi, input bit gap);
    for (int k = lo; k <= hi; k++) begin
      if (gap && k > 0) begin
        in_valid = 1'b0;
        step();
      end
      in_valid = 1'b1;
      in0_re = smp[0][k];
      in0_im = smp[1][k];
      in1_re = smp[2][k];
      in1_im = smp[3][k];
      step();
    end
  endtask

  task automatic do_reset();
    RST = 1'b1;
    in_valid = 1'b0;
    step();
    RST = 1'b0;
  endtask

  initial begin
    RST = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    in0_re = '0; in0_im = '0; in1_re = '0; in1_im = '0;
    vecs[0] = '{"single", 1'b0, {16'h0300, 16'h0200, 16'h0100, 16'h0000}, 16'h0001,
                16'h0000, 16'h001F, 16'h031F};
    vecs[1] = '{"gapped", 1'b1, {16'h0300, 16'h0200, 16'h0100, 16'h0000}, 16'h0001,
                16'h0000, 16'h001F, 16'h031F};
    vecs[2] = '{"ramp", 1'b0, {16'h1234, 16'h7FFF, 16'h8000, 16'hFFF0}, 16'h0101,
                16'hFFF0, 16'h1F0F, 16'h3153};
    vecs[3] = '{"ones", 1'b1, {16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF}, 16'h0000,
                16'hFFFF, 16'hFFFF, 16'hFFFF};

    step(); step();
    chk("rst_valid", W'(out_valid), '0);
    chk("rst_addr", W'(out_addr), '0);
    chk("rst_ovf", W'(overflow), '0);
    chk("rst_busy", W'(busy), '0);
    chk("rst_0re", out0_re, '0);
    chk("rst_1im", out1_im, '0);
    RST = 1'b0;

    for (int v = 0; v < 4; v++) begin
      fill_lin(vecs[v].base, vecs[v].stp);
      do_reset();
      out_ready = 1'b1;
      drive(0, 30, vecs[v].gap);
      chk({vecs[v].name, "_pre_valid"}, W'(out_valid), '0);
      chk({vecs[v].name, "_pre_busy"}, W'(busy), W'(1));
      drive(31, 31, vecs[v].gap);
      in_valid = 1'b0;
      chk({vecs[v].name, "_valid"}, W'(out_valid), W'(1));
      chk({vecs[v].name, "_addr0"}, W'(out_addr), '0);
      chk({vecs[v].name, "_top0re"}, W'(out0_re[511:496]), W'(vecs[v].e_top0re));
      chk({vecs[v].name, "_lo0re"}, W'(out0_re[15:0]), W'(vecs[v].e_lo0re));
      chk({vecs[v].name, "_lo1im"}, W'(out1_im[15:0]), W'(vecs[v].e_lo1im));
      chk_frame(vecs[v].name);
      step();
      chk({vecs[v].name, "_post_valid"}, W'(out_valid), '0);
      chk({vecs[v].name, "_addr1"}, W'(out_addr), W'(1));
      chk({vecs[v].name, "_post_busy"}, W'(busy), '0);
      chk({vecs[v].name, "_ovf"}, W'(overflow), '0);
    end

    // Continuous frames, no bubbles, bank always ready.
    do_reset();
    out_ready = 1'b1;
    bb_en = 1'b1;
    for (int f = 0; f < 1000; f++) begin
      fill_rand();
      drive(0, 31, 1'b0);
      chk("bb_valid", W'(out_valid), W'(1));
      chk("bb_addr", W'(out_addr), W'(f));
      chk_frame("bb");
    end
    in_valid = 1'b0;
    step();
    bb_en = 1'b0;
    chk("bb_valid_cycles", W'(bb_cnt), W'(1000));
    chk("bb_ovf", W'(overflow), '0);
    chk("bb_addr_end", W'(out_addr), W'(1000));

    // Backpressure: second frame dropped while the first is held.
    do_reset();
    out_ready = 1'b0;
    fill_rand();
    drive(0, 31, 1'b0);
    in_valid = 1'b0;
    for (int l = 0; l < 4; l++) a_w[l] = pack(l);
    chk("bp_held_valid", W'(out_valid), W'(1));
    chk("bp_held_ovf", W'(overflow), '0);
    fill_rand();
    drive(0, 31, 1'b0);
    in_valid = 1'b0;
    chk("bp_drop_ovf", W'(overflow), W'(1));
    chk("bp_drop_valid", W'(out_valid), W'(1));
    chk("bp_drop_addr", W'(out_addr), '0);
    chk("bp_keep_0re", out0_re, a_w[0]);
    chk("bp_keep_1im", out1_im, a_w[3]);
    out_ready = 1'b1;
    step();
    chk("bp_pop_valid", W'(out_valid), '0);
    chk("bp_pop_addr", W'(out_addr), W'(1));
    chk("bp_ovf_sticky", W'(overflow), W'(1));

    // Ready arrives exactly in the completion cycle of the second frame.
    do_reset();
    out_ready = 1'b0;
    fill_rand();
    drive(0, 31, 1'b0);
    fill_rand();
    drive(0, 30, 1'b0);
    out_ready = 1'b1;
    drive(31, 31, 1'b0);
    in_valid = 1'b0;
    chk("bp2_valid", W'(out_valid), W'(1));
    chk("bp2_addr", W'(out_addr), W'(1));
    chk("bp2_ovf", W'(overflow), '0);
    chk_frame("bp2");
    step();
    chk("bp2_pop_valid", W'(out_valid), '0);
    chk("bp2_pop_addr", W'(out_addr), W'(2));

    // Address wrap on the 3-bit instance.
    do_reset();
    out_ready = 1'b1;
    for (int f = 0; f < 9; f++) begin
      fill_rand();
      drive(0, 31, 1'b0);
      chk("wrap_valid", W'(w_valid), W'(1));
      chk("wrap_addr", W'(w_addr), W'(f % 8));
    end
    in_valid = 1'b0;
    step();
    chk("wrap_addr_end", W'(w_addr), W'(1));
    chk("wrap_main_addr", W'(out_addr), W'(9));

    // Reset mid-frame with a held frame and overflow pending; sample during reset ignored.
    do_reset();
    out_ready = 1'b0;
    fill_rand();
    drive(0, 31, 1'b0);
    drive(0, 31, 1'b0);
    drive(0, 16, 1'b0);
    RST = 1'b1;
    in_valid = 1'b1;
    step();
    chk("mr_busy", W'(busy), '0);
    chk("mr_ovf", W'(overflow), '0);
    chk("mr_valid", W'(out_valid), '0);
    chk("mr_addr", W'(out_addr), '0);
    chk("mr_0re", out0_re, '0);
    RST = 1'b0;
    out_ready = 1'b1;
    fill_lin({16'hC000, 16'h8000, 16'h4000, 16'h0005}, 16'h0003);
    drive(0, 31, 1'b0);
    in_valid = 1'b0;
    chk("mr_new_valid", W'(out_valid), W'(1));
    chk("mr_new_addr", W'(out_addr), '0);
    chk("mr_new_ovf", W'(overflow), '0);
    chk("mr_top0re", W'(out0_re[511:496]), W'(16'h0005));
    chk_frame("mr");
    step();
    chk("mr_addr1", W'(out_addr), W'(1));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
